// File: rtl/cs_window_filter_pkg.sv
// rtl/cs_window_filter_pkg.sv - shared defaults, width helpers and stage-valid type for cs_window_filter
package cs_pkg;

    localparam int CS_DW_DEF    = 8;
    localparam int CS_WIN_DEF   = 9;
    localparam int CS_SHIFT_DEF = 3;

    // Running window sum: WIN samples of DW bits.
    function automatic int sum_w(input int dw, input int win);
        return dw + $clog2(win);
    endfunction

    // WIN * sample never exceeds WIN * (2^DW - 1) < 2^(DW + clog2(WIN)).
    function automatic int prod_w(input int dw, input int win);
        return dw + $clog2(win);
    endfunction

    function automatic int tot_w(input int dw, input int win);
        return dw + $clog2(2 * win);
    endfunction

    function automatic int y_w(input int dw, input int win, input int shift);
        return tot_w(dw, win) - shift;
    endfunction

    function automatic int cnt_w(input int win);
        return $clog2(win + 1);
    endfunction

    typedef struct packed {
        logic b;
        logic c;
    } stage_vld_t;

endpackage

// File: rtl/cs_window_filter_if.sv
// rtl/cs_window_filter_if.sv - sample-in / result-out bundle of cs_window_filter
interface cs_window_filter_if
    import cs_pkg::*;
#(
    parameter int DW = CS_DW_DEF,
    parameter int YW = y_w(CS_DW_DEF, CS_WIN_DEF, CS_SHIFT_DEF),
    parameter int CW = cnt_w(CS_WIN_DEF)
);
    logic          in_valid;
    logic [DW-1:0] X;
    logic          out_valid;
    logic [YW-1:0] Y;
    logic [CW-1:0] fill_cnt;

    modport master (
        output in_valid,
        output X,
        input  out_valid,
        input  Y,
        input  fill_cnt
    );

    modport slave (
        input  in_valid,
        input  X,
        output out_valid,
        output Y,
        output fill_cnt
    );

endinterface

// File: rtl/cs_window_filter_window.sv
// rtl/cs_window_filter_window.sv - Stage A: sample shift register, running sum and fill counter
module cs_window
    import cs_pkg::*;
#(
    parameter  int DW  = CS_DW_DEF,
    parameter  int WIN = CS_WIN_DEF,
    localparam int SW  = sum_w(DW, WIN),
    localparam int CW  = cnt_w(WIN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic [DW-1:0]           x,
    output logic [WIN-1:0][DW-1:0]  win,
    output logic [SW-1:0]           sum,
    output logic [CW-1:0]           fill_cnt,
    output logic                    win_valid
);

    localparam logic [CW-1:0] FULL = CW'(WIN);

    logic [CW-1:0] fill_nxt;

    assign fill_nxt = (fill_cnt == FULL) ? FULL : fill_cnt + 1'b1;

    // win[0] is the newest sample; win[WIN-1] is zero until the window has filled,
    // so subtracting it keeps the sum exact during fill.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win       <= '0;
            sum       <= '0;
            fill_cnt  <= '0;
            win_valid <= 1'b0;
        end else if (clear) begin
            win       <= '0;
            sum       <= '0;
            fill_cnt  <= '0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= in_valid && (fill_nxt == FULL);
            if (in_valid) begin
                win      <= {win[WIN-2:0], x};
                sum      <= sum + {{(SW-DW){1'b0}}, x} - {{(SW-DW){1'b0}}, win[WIN-1]};
                fill_cnt <= fill_nxt;
            end
        end
    end

endmodule

// File: rtl/cs_window_filter.sv
// rtl/cs_window_filter.sv - CS approximate-average sliding-window filter top (Stage B select, Stage C output)
// Build option CS_ROUND_EN: round-half-up output with saturation instead of floor.
module cs_window_filter
    import cs_pkg::*;
#(
    parameter int DW    = CS_DW_DEF,
    parameter int WIN   = CS_WIN_DEF,
    parameter int SHIFT = CS_SHIFT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    cs_window_filter_if.slave  bus
);

    localparam int SW = sum_w(DW, WIN);
    localparam int PW = prod_w(DW, WIN);
    localparam int TW = tot_w(DW, WIN);
    localparam int YW = y_w(DW, WIN, SHIFT);
    localparam int CW = cnt_w(WIN);

    localparam logic [PW-1:0] WIN_P = PW'(WIN);

    logic [WIN-1:0][DW-1:0] win;
    logic [SW-1:0]          sum;
    logic [CW-1:0]          fill_cnt;
    logic                   win_valid;

    logic [DW-1:0]          xappr_d;
    logic [DW-1:0]          xappr_q;
    logic [SW-1:0]          sum_q;
    stage_vld_t             vld_q;

    logic [TW-1:0]          tot;
    logic [YW-1:0]          y_d;
    logic [YW-1:0]          y_q;

    cs_window #(
        .DW  (DW),
        .WIN (WIN)
    ) u_window (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (bus.in_valid),
        .x         (bus.X),
        .win       (win),
        .sum       (sum),
        .fill_cnt  (fill_cnt),
        .win_valid (win_valid)
    );

    // Largest sample w with WIN*w <= S, i.e. w <= floor(mean), without a divider.
    always_comb begin
        xappr_d = '0;
        for (int i = 0; i < WIN; i++) begin
            if (((WIN_P * PW'(win[i])) <= PW'(sum)) && (win[i] >= xappr_d)) begin
                xappr_d = win[i];
            end
        end
    end

    assign tot = TW'(sum_q) + TW'(WIN_P * PW'(xappr_q));

`ifdef CS_ROUND_EN
    localparam logic [TW:0] HALF = {{TW{1'b0}}, 1'b1} << (SHIFT - 1);

    logic [TW:0] tot_rnd;
    logic [YW:0] y_rnd;

    always_comb begin
        tot_rnd = {1'b0, tot} + HALF;
        y_rnd   = (YW+1)'(tot_rnd >> SHIFT);
        y_d     = y_rnd[YW] ? '1 : y_rnd[YW-1:0];
    end
`else
    assign y_d = YW'(tot >> SHIFT);
`endif

    // clear kills whatever is in flight in Stage B and Stage C.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xappr_q <= '0;
            sum_q   <= '0;
            vld_q   <= '0;
            y_q     <= '0;
        end else begin
            vld_q.b <= win_valid & ~clear;
            vld_q.c <= vld_q.b & ~clear;
            if (win_valid && !clear) begin
                xappr_q <= xappr_d;
                sum_q   <= sum;
            end
            if (vld_q.b && !clear) begin
                y_q <= y_d;
            end
        end
    end

    assign bus.out_valid = vld_q.c;
    assign bus.Y         = y_q;
    assign bus.fill_cnt  = fill_cnt;

endmodule

// File: tb/tb_cs_window_filter.sv
// tb/tb_cs_window_filter.sv - directed self-checking bench for cs_window_filter
module tb_cs_window_filter;
    import cs_pkg::*;

    localparam int DW    = 8;
    localparam int WIN   = 9;
    localparam int SHIFT = 3;
    localparam int YW    = y_w(DW, WIN, SHIFT);
    localparam int CW    = cnt_w(WIN);

    logic clk;
    logic rst_n;
    logic clear;

    int errors;
    int checks;
    int pulses;
    int last_y;

    byte unsigned q[$];

    cs_window_filter_if #(.DW(DW), .YW(YW), .CW(CW)) bus ();

    cs_window_filter #(
        .DW    (DW),
        .WIN   (WIN),
        .SHIFT (SHIFT)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] x, input logic clr);
        bus.in_valid = v;
        bus.X        = x;
        clear        = clr;
        @(posedge clk);
        #1;
        if (bus.out_valid) begin
            pulses++;
            last_y = int'(bus.Y);
        end
    endtask

    task automatic run_window(input string tag, input int exp_y);
        step(1'b0, 8'd0, 1'b1);
        pulses = 0;
        foreach (q[i]) step(1'b1, q[i], 1'b0);
        repeat (3) step(1'b0, 8'd0, 1'b0);
        check({tag, "_pulses"}, pulses, 1);
        check({tag, "_y"}, last_y, exp_y);
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        pulses       = 0;
        last_y       = 0;
        rst_n        = 1'b0;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        bus.X        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_y", int'(bus.Y), 0);
        check("rst_fill", int'(bus.fill_cnt), 0);

        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i * 10), 1'b0);
        check("partial_fill", int'(bus.fill_cnt), 5);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_fill", int'(bus.fill_cnt), 0);
        step(1'b0, 8'd0, 1'b0);
        rst_n = 1'b1;

        // Fresh window after reset: output two edges after the 9th sample.
        pulses = 0;
        for (int i = 1; i <= 9; i++) step(1'b1, 8'(i), 1'b0);
        check("no_early_out", pulses, 0);
        check("fill_full", int'(bus.fill_cnt), 9);
        step(1'b0, 8'd0, 1'b0);
        check("lat_k1_ov", int'(bus.out_valid), 0);
        step(1'b0, 8'd0, 1'b0);
        check("lat_k2_ov", int'(bus.out_valid), 1);
        check("lat_k2_y", int'(bus.Y), 'h00B);
        step(1'b0, 8'd0, 1'b0);
        check("pulse_end_ov", int'(bus.out_valid), 0);
        check("y_hold", int'(bus.Y), 'h00B);

        // Back-to-back samples 1..10 give back-to-back results.
        step(1'b0, 8'd0, 1'b1);
        pulses = 0;
        for (int i = 1; i <= 10; i++) step(1'b1, 8'(i), 1'b0);
        check("sat_fill", int'(bus.fill_cnt), 9);
        step(1'b0, 8'd0, 1'b0);
        check("b2b_first_ov", int'(bus.out_valid), 1);
        check("b2b_first_y", int'(bus.Y), 'h00B);
        step(1'b0, 8'd0, 1'b0);
        check("b2b_second_ov", int'(bus.out_valid), 1);
        check("b2b_second_y", int'(bus.Y), 'h00D);
        step(1'b0, 8'd0, 1'b0);
        check("b2b_pulses", pulses, 2);

        q = {8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        run_window("max", 'h23D);
        q = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd90};
        run_window("xappr0", 'h00B);
`ifdef CS_ROUND_EN
        q = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd12};
        run_window("round", 'h00C);
`else
        q = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd12};
        run_window("floor", 'h00B);
`endif

        // Gaps of three idle cycles between samples.
        step(1'b0, 8'd0, 1'b1);
        pulses = 0;
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 8'(i), 1'b0);
            repeat (3) step(1'b0, 8'd0, 1'b0);
            if (i == 4) check("gap_fill_stall", int'(bus.fill_cnt), 4);
        end
        check("gap_pulses", pulses, 1);
        check("gap_y", last_y, 'h00B);

        // clear with a simultaneous sample right after the window completes.
        step(1'b0, 8'd0, 1'b1);
        pulses = 0;
        for (int i = 1; i <= 9; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'd99, 1'b1);
        check("clr_fill", int'(bus.fill_cnt), 0);
        check("clr_ov0", int'(bus.out_valid), 0);
        step(1'b0, 8'd0, 1'b0);
        check("clr_ov1", int'(bus.out_valid), 0);
        step(1'b0, 8'd0, 1'b0);
        check("clr_killed", pulses, 0);
        for (int i = 1; i <= 8; i++) step(1'b1, 8'd7, 1'b0);
        repeat (3) step(1'b0, 8'd0, 1'b0);
        check("clr_needs_win", pulses, 0);
        step(1'b1, 8'd7, 1'b0);
        repeat (3) step(1'b0, 8'd0, 1'b0);
        check("clr_refill_pulses", pulses, 1);
        check("clr_refill_y", last_y, 'h00F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cs_window_filter.md
Name: cs_window_filter

Overview:
- Parameterised successor to the fixed 9-sample, 8-bit CS approximate-average filter.
- Streaming sliding-window filter. For each new window it:
  - computes the window sum S;
  - picks Xappr, the largest window sample not exceeding the mean;
  - outputs Y = (S + WIN*Xappr) >> SHIFT.
- Adds over the fixed version: generic width/window/scale, a valid handshake with input gaps, a synchronous clear, and a fill counter.
- Sits between the sample source and the downstream accumulator.

Parameters:
- DW, 8: input sample width.
- WIN, 9: window length in samples, >= 2.
- SHIFT, 3: output divide exponent (divide by 2^SHIFT), SHIFT >= 1.
- YW, DW+$clog2(2*WIN)-SHIFT: output width; derived, not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; low clears all state.
- clear  in  1  synchronous window flush.
- in_valid  in  1  X is a sample this cycle.
- X  in  DW  unsigned input sample.
- out_valid  out  1  Y valid; one-cycle pulse per result.
- Y  out  YW  filtered result, unsigned.
- fill_cnt  out  $clog2(WIN+1)  samples held, saturates at WIN.

Behaviour:
- Reset (reset low, asynchronous): window registers, S, fill_cnt, pipeline registers, out_valid and Y all go to 0. Reset mid-stream discards partial windows; after release, WIN fresh samples are needed before any output.
- Stage A, at the edge where in_valid=1:
  - shift X into the window and drop the oldest sample;
  - update the running sum: S <= S + X - oldest. Width is DW+$clog2(WIN); no full re-summing;
  - increment fill_cnt, saturating at WIN.
  - The oldest sample is 0 while not full, so S is exact during fill.
- Window qualification: a Stage-A edge that leaves fill_cnt==WIN marks the window valid for the pipeline.
- Stage B, next edge:
  - Xappr = max over the window of samples w with WIN*w <= S. This is equivalent to w <= floor(S/WIN); no divider allowed.
  - The minimum sample always qualifies, so Xappr is always defined.
  - Register Xappr and S.
- Stage C, next edge:
  - Y <= (S + WIN*Xappr) >> SHIFT, floor.
  - out_valid <= 1 for exactly one cycle.
- Latency: the sample accepted at edge k yields out_valid high after edge k+2. The pipeline is fully pipelined; back-to-back in_valid gives back-to-back outputs.
- in_valid=0: window, S and fill_cnt hold; no new result enters the pipeline. In-flight results still emerge.
- clear=1 at an edge:
  - window, S and fill_cnt go to 0;
  - in-flight Stage B/C results are killed; out_valid=0 on the following cycle;
  - clear has priority over in_valid, and the simultaneous sample is dropped.
- Y holds its last value when out_valid=0.
- No overflow is possible: YW covers (2*WIN*(2^DW-1)) >> SHIFT.

Optional Feature:
- Macro: CS_ROUND_EN.
- Defined: Stage C computes Y = (S + WIN*Xappr + 2^(SHIFT-1)) >> SHIFT, round-half-up. The sum is widened by one bit internally and Y is saturated to 2^YW-1.
- Undefined: floor as above, identical to the existing CS results at default parameters.

Decomposition:
- Package cs_pkg holds:
  - default DW, WIN and SHIFT;
  - width functions for sum, product, YW and counter;
  - a stage-valid struct typedef.
- Sub-module cs_window: shift register, running sum and fill_cnt (Stage A), exposing the window array, S and win_valid.
- The top holds the Stage B selection and the Stage C arithmetic.

Test Plan:
- Reset low mid-stream after 5 samples, release, feed 1..9 -> no out_valid until the 9th sample; then Y=0x00B two cycles later (S=45, Xappr=5).
- Continuous 1..10 -> second result Y=0x00D (window 2..10, S=54, Xappr=6), on the cycle after the first.
- Nine samples of 255 -> Y=0x23D; eight 0 then 90 -> Y=0x00B (Xappr=0).
- Samples 1..8,12 -> floor Y=0x00B; with CS_ROUND_EN, Y=0x00C (93 vs 97, >>3).
- Gaps: 1..9 with in_valid dropping for 3 cycles between samples -> same Y=0x00B, fill_cnt stalls during gaps, a single out_valid pulse.
- clear asserted with in_valid in the cycle after the 9th sample -> in-flight results killed (no out_valid in the following two cycles), fill_cnt=0, and WIN new samples are required before the next output.
